// File: rtl/cpu_params_pkg.sv
// Shared types and constants for the external I/O register bank (eio_reg_bank).
// The optional IRQ control register is enabled in eio_reg_bank by EIO_REG_BANK_IRQ_EN.
package cpu_params_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } eio_state_e;

  localparam logic [31:0] EIO_REG_BANK_ID = 32'h524B_0001;

  // Bit positions inside the IRQ control register (top register of the bank).
  localparam int unsigned IRQ_EN_BIT   = 0;
  localparam int unsigned IRQ_PEND_BIT = 1;

  // Wide enough for the largest wait-state count (15).
  localparam int unsigned EIO_CTR_W = 4;

  // The counter is loaded on the IDLE-exit edge, and WAIT leaves on the edge where it reads 0,
  // so loading WAIT_CYC-1 yields exactly WAIT_CYC cycles in WAIT.
  function automatic logic [EIO_CTR_W-1:0] wait_load_val(input int unsigned wait_cyc);
    return (wait_cyc > 0) ? EIO_CTR_W'(wait_cyc - 1) : '0;
  endfunction

endpackage

// File: rtl/eio_wait_ctr.sv
// Loadable wait-state down-counter for eio_reg_bank; done is high whenever the count is zero.
module eio_wait_ctr
  import cpu_params_pkg::*;
#(
  parameter int unsigned CTR_W = EIO_CTR_W
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             load,
  input  logic             en,
  input  logic [CTR_W-1:0] load_val,
  output logic             done
);

  logic [CTR_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/eio_reg_bank.sv
// Memory-mapped bank of 32-bit registers with wait states and a req/ack handshake.
// Define EIO_REG_BANK_IRQ_EN to turn the top register into an IRQ enable/pending control.
module eio_reg_bank
  import cpu_params_pkg::*;
#(
  parameter int          NUM_REGS  = 8,
  parameter int          WAIT_CYC  = 2,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] ID_VAL    = EIO_REG_BANK_ID
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        req_in,
  input  logic        rd_in,
  input  logic        wr_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wr_data_in,
  output logic        ack_out,
  output logic        ack_fault_out,
  output logic [31:0] ack_data_out,
  output logic        irq_out
);

  localparam int unsigned         IDX_W     = $clog2(NUM_REGS);
  localparam logic [EIO_CTR_W-1:0] WAIT_LOAD = wait_load_val(WAIT_CYC);

  eio_state_e state, next_state;
  logic       ctr_load;
  logic       ctr_done;

  logic        cap_rd;
  logic        cap_wr;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             fault;
  logic             wr_ok;
  logic             rd_ok;

  logic [31:0] regs [NUM_REGS];
  logic        id_armed;
  logic [31:0] rd_val;

  logic        irq_hit;
  logic [31:0] irq_rd_val;

  eio_wait_ctr #(
    .CTR_W (EIO_CTR_W)
  ) u_wait_ctr (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .load     (ctr_load),
    .en       (state == WAIT),
    .load_val (WAIT_LOAD),
    .done     (ctr_done)
  );

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    ctr_load   = 1'b0;
    case (state)
      IDLE: begin
        if (req_in) begin
          ctr_load   = 1'b1;
          next_state = (WAIT_CYC == 0) ? ACK : WAIT;
        end
      end
      WAIT:    if (ctr_done) next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The access is frozen on the IDLE-exit edge; later input changes cannot affect it.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      cap_rd    <= 1'b0;
      cap_wr    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if ((state == IDLE) && req_in) begin
      cap_rd    <= rd_in;
      cap_wr    <= wr_in;
      cap_addr  <= addr_in;
      cap_wdata <= wr_data_in;
    end
  end

  // Addresses below BASE_ADDR wrap to a huge offset and so fall out of range.
  assign offset = cap_addr - BASE_ADDR;
  assign idx    = offset[IDX_W+1:2];
  assign fault  = ((offset >> 2) >= 32'(NUM_REGS)) || (offset[1:0] != 2'b00) || (cap_rd == cap_wr);
  assign wr_ok  = (state == ACK) && !fault && cap_wr;
  assign rd_ok  = (state == ACK) && !fault && cap_rd;

  // NOTE: the register array is reset as a whole because reads after reset must return 0.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      regs     <= '{default: '0};
      id_armed <= 1'b1;
    end else if (wr_ok) begin
      if (!irq_hit) regs[idx] <= cap_wdata;
      if (idx == '0) id_armed <= 1'b0;
    end
  end

  always_comb begin
    rd_val = regs[idx];
    if (irq_hit) begin
      rd_val = irq_rd_val;
    end else if ((idx == '0) && id_armed) begin
      rd_val = ID_VAL;
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      ack_out       <= 1'b0;
      ack_fault_out <= 1'b0;
      ack_data_out  <= '0;
    end else begin
      ack_out       <= (state == ACK);
      ack_fault_out <= (state == ACK) && fault;
      ack_data_out  <= rd_ok ? rd_val : '0;
    end
  end

`ifdef EIO_REG_BANK_IRQ_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  logic irq_en;
  logic irq_pend;

  assign irq_hit = (idx == LAST_IDX);

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      irq_en   <= 1'b0;
      irq_pend <= 1'b0;
      irq_out  <= 1'b0;
    end else begin
      if (wr_ok && irq_hit) begin
        irq_en <= cap_wdata[IRQ_EN_BIT];
        if (cap_wdata[IRQ_PEND_BIT]) irq_pend <= 1'b0;
      end
      // Assigned last so a set beats a clear landing on the same edge.
      if (wr_ok && (idx == '0)) irq_pend <= 1'b1;
      irq_out <= irq_en & irq_pend;
    end
  end

  always_comb begin
    irq_rd_val               = '0;
    irq_rd_val[IRQ_EN_BIT]   = irq_en;
    irq_rd_val[IRQ_PEND_BIT] = irq_pend;
  end
`else
  assign irq_hit    = 1'b0;
  assign irq_rd_val = '0;
  assign irq_out    = 1'b0;
`endif

endmodule

// File: tb/tb_eio_reg_bank.sv
// Scoreboard bench for eio_reg_bank: u_eio sits where the external I/O device hangs off EIO_bus
// (WAIT_CYC=2); u_eio0 (WAIT_CYC=0) covers back-to-back acks with req held high.
module tb_eio_reg_bank;

  localparam int          W    = 2;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] ID   = 32'h524B_0001;

  typedef struct {
    string       tag;
    int          cyc;
    logic        fault;
    logic [31:0] data;
  } sb_item_t;

  sb_item_t sb_q[$];
  sb_item_t mon_it;
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic        clk_in   = 1'b0;
  logic        reset_in = 1'b0;
  logic        req = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        ack, ack_fault, irq;
  logic [31:0] ack_data;

  logic        req0 = 1'b0, rd0 = 1'b0, wr0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic        ack0, fault0, irq0;
  logic [31:0] data0;

  eio_reg_bank #(.NUM_REGS(8), .WAIT_CYC(W), .BASE_ADDR(BASE), .ID_VAL(ID)) u_eio (
    .clk_in(clk_in), .reset_in(reset_in), .req_in(req), .rd_in(rd), .wr_in(wr),
    .addr_in(addr), .wr_data_in(wdata), .ack_out(ack), .ack_fault_out(ack_fault),
    .ack_data_out(ack_data), .irq_out(irq)
  );

  eio_reg_bank #(.NUM_REGS(8), .WAIT_CYC(0), .BASE_ADDR(BASE), .ID_VAL(ID)) u_eio0 (
    .clk_in(clk_in), .reset_in(reset_in), .req_in(req0), .rd_in(rd0), .wr_in(wr0),
    .addr_in(addr0), .wr_data_in(wdata0), .ack_out(ack0), .ack_fault_out(fault0),
    .ack_data_out(data0), .irq_out(irq0)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every ack must match the oldest expectation, including the cycle it lands in.
  always @(negedge clk_in) begin
    if (ack) begin
      if (sb_q.size() == 0) begin
        check("spurious_ack", 32'(ack), 32'd0);
      end else begin
        mon_it = sb_q.pop_front();
        check({mon_it.tag, "_cycle"}, cyc, mon_it.cyc);
        check({mon_it.tag, "_fault"}, 32'(ack_fault), 32'(mon_it.fault));
        check({mon_it.tag, "_data"}, ack_data, mon_it.data);
      end
    end
  end

  // Issue one access; inputs are scrambled right after the capturing edge.
  task automatic access(input string tag, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic ef, input logic [31:0] ed);
    sb_item_t it;
    logic got;
    @(negedge clk_in);
    rd = r; wr = w; addr = a; wdata = d; req = 1'b1;
    it.tag = tag; it.cyc = cyc + W + 2; it.fault = ef; it.data = ed;
    sb_q.push_back(it);
    @(negedge clk_in);
    rd = ~r; wr = ~w; addr = ~a; wdata = ~d;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ack) begin
        got = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
    req = 1'b0;
    check({tag, "_ack_seen"}, 32'(got), 32'd1);
    if (!got) void'(sb_q.pop_back());
  endtask

  initial begin
    int k;
    int n_ack;
    int ack_cyc [2];

    repeat (3) @(negedge clk_in);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_fault", 32'(ack_fault), 32'd0);
    check("rst_data", ack_data, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    reset_in = 1'b1;

    access("rd_id",        1, 0, 32'h8000_0000, 32'h0,         0, ID);
    access("wr_r2",        0, 1, 32'h8000_0008, 32'hDEAD_BEEF, 0, 32'h0);
    access("rd_r2",        1, 0, 32'h8000_0008, 32'h0,         0, 32'hDEAD_BEEF);
    access("rd_r3",        1, 0, 32'h8000_000C, 32'h0,         0, 32'h0);
    access("rd_oob",       1, 0, 32'h8000_0020, 32'h0,         1, 32'h0);
    access("rd_misalign",  1, 0, 32'h8000_0002, 32'h0,         1, 32'h0);
    access("wr_oob",       0, 1, 32'h8000_0020, 32'h1111_1111, 1, 32'h0);
    access("wr_misalign",  0, 1, 32'h8000_000A, 32'h2222_2222, 1, 32'h0);
    access("rdwr_both",    1, 1, 32'h8000_0008, 32'h5555_5555, 1, 32'h0);
    access("rdwr_none",    0, 0, 32'h8000_0008, 32'h6666_6666, 1, 32'h0);
    access("below_base",   1, 0, 32'h7FFF_FFFC, 32'h0,         1, 32'h0);
    access("rd_r2_kept",   1, 0, 32'h8000_0008, 32'h0,         0, 32'hDEAD_BEEF);
    access("rd_r0_kept",   1, 0, 32'h8000_0000, 32'h0,         0, ID);
    access("wr_r0",        0, 1, 32'h8000_0000, 32'h1234_5678, 0, 32'h0);
    access("rd_r0",        1, 0, 32'h8000_0000, 32'h0,         0, 32'h1234_5678);

`ifdef EIO_REG_BANK_IRQ_EN
    access("irq_clr",      0, 1, 32'h8000_001C, 32'h2,         0, 32'h0);
    access("irq_rd_clr",   1, 0, 32'h8000_001C, 32'h0,         0, 32'h0);
    access("irq_en",       0, 1, 32'h8000_001C, 32'h1,         0, 32'h0);
    access("irq_rd_en",    1, 0, 32'h8000_001C, 32'h0,         0, 32'h1);
    access("irq_set",      0, 1, 32'h8000_0000, 32'h0,         0, 32'h0);
    check("irq_at_ack", 32'(irq), 32'd0);
    @(negedge clk_in);
    check("irq_after_ack", 32'(irq), 32'd1);
    access("irq_rd_pend",  1, 0, 32'h8000_001C, 32'h0,         0, 32'h3);
    access("irq_clr2",     0, 1, 32'h8000_001C, 32'h2,         0, 32'h0);
    @(negedge clk_in);
    check("irq_cleared", 32'(irq), 32'd0);
`else
    access("wr_r7",        0, 1, 32'h8000_001C, 32'hA5A5_0003, 0, 32'h0);
    access("rd_r7",        1, 0, 32'h8000_001C, 32'h0,         0, 32'hA5A5_0003);
    @(negedge clk_in);
    check("irq_tied_low", 32'(irq), 32'd0);
`endif

    // Zero wait states, req held high: acks must arrive every second cycle.
    ack_cyc[0] = -100;
    ack_cyc[1] = -100;
    n_ack = 0;
    @(negedge clk_in);
    k = cyc;
    rd0 = 1'b1; wr0 = 1'b0; addr0 = BASE; req0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      if (ack0 && (n_ack < 2)) begin
        if (n_ack == 0) begin
          check("w0_data", data0, ID);
          check("w0_fault", 32'(fault0), 32'd0);
        end
        ack_cyc[n_ack] = cyc;
        n_ack++;
      end
    end
    req0 = 1'b0;
    check("w0_first_latency", ack_cyc[0], k + 2);
    check("w0_ack_gap", ack_cyc[1] - ack_cyc[0], 32'd2);
    repeat (3) @(negedge clk_in);
    check("w0_irq", 32'(irq0), 32'd0);

    // Reset during WAIT of a write to reg 3: no ack, no write, ID re-armed.
    @(negedge clk_in);
    rd = 1'b0; wr = 1'b1; addr = 32'h8000_000C; wdata = 32'hCAFE_F00D; req = 1'b1;
    @(negedge clk_in);
    reset_in = 1'b0;
    req = 1'b0;
    check("abort_ack_in_rst", 32'(ack), 32'd0);
    check("abort_irq_in_rst", 32'(irq), 32'd0);
    repeat (2) @(negedge clk_in);
    reset_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      check("abort_no_ack", 32'(ack), 32'd0);
    end
    access("rd_r3_abort",  1, 0, 32'h8000_000C, 32'h0,         0, 32'h0);
    access("rd_r2_rst",    1, 0, 32'h8000_0008, 32'h0,         0, 32'h0);
    access("rd_id_rearm",  1, 0, 32'h8000_0000, 32'h0,         0, ID);

    repeat (4) @(negedge clk_in);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
